// File: rtl/rgb_frame_ctrl_pkg.sv
// Shared definitions for the RGB frame sequencer: FSM states, byte order and pixel byte selection.
package rgb_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_LATCH
  } state_e;

  // Wire order of the three colour bytes within one pixel.
  localparam logic [1:0] BYTE_G = 2'd0;
  localparam logic [1:0] BYTE_R = 2'd1;
  localparam logic [1:0] BYTE_B = 2'd2;

  function automatic logic [7:0] pix_byte(input logic [23:0] pix, input logic [1:0] idx);
    case (idx)
      BYTE_G:  return pix[23:16];
      BYTE_R:  return pix[15:8];
      default: return pix[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rgb_latch_timer.sv
// Loadable down-counter that times the low latch gap after a frame; zero flags expiry.
module rgb_latch_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rgb_frame_ctrl.sv
// Frame sequencer: fetches NUM_LEDS pixels, streams them byte-wise (G,R,B) to the
// serial driver with one-pixel prefetch, then holds the line low for the latch gap.
module rgb_frame_ctrl
  import rgb_frame_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned LATCH_CYCLES = 4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       cfg_clkmax,
  input  logic [15:0]       cfg_hi1,
  input  logic [15:0]       cfg_hi0,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              drv_en,
  output logic [7:0]        drv_data,
  output logic [15:0]       drv_clkmax,
  output logic [15:0]       drv_hi1,
  output logic [15:0]       drv_hi0,
  input  logic              drv_byte_done,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       LAT_W    = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(LATCH_CYCLES - 1);

  state_e            state_q, state_d;
  logic              pix_rd_q, pix_rd_d;
  logic              rd_dly_q, rd_dly_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       cur_pix_q, cur_pix_d;
  logic [23:0]       nxt_pix_q, nxt_pix_d;
  logic              drv_en_q, drv_en_d;
  logic [7:0]        drv_data_q, drv_data_d;
  logic [15:0]       clkmax_q, clkmax_d;
  logic [15:0]       hi1_q, hi1_d;
  logic [15:0]       hi0_q, hi0_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  rgb_latch_timer #(.W(LAT_W)) u_latch_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (LAT_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
    state_d    = state_q;
    pix_rd_d   = 1'b0;
    rd_dly_d   = pix_rd_q;
    pix_addr_d = pix_addr_q;
    pix_idx_d  = pix_idx_q;
    byte_idx_d = byte_idx_q;
    cur_pix_d  = cur_pix_q;
    nxt_pix_d  = nxt_pix_q;
    drv_en_d   = drv_en_q;
    drv_data_d = drv_data_q;
    clkmax_d   = clkmax_q;
    hi1_d      = hi1_q;
    hi0_d      = hi0_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    // Prefetched pixel arrives the cycle after its read strobe.
    if (rd_dly_q && state_q == ST_SEND) nxt_pix_d = pix_data;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop && !done_q) begin
          clkmax_d   = cfg_clkmax;
          hi1_d      = cfg_hi1;
          hi0_d      = cfg_hi0;
          pix_addr_d = '0;
          pix_idx_d  = '0;
          pix_rd_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        cur_pix_d  = pix_data;
        drv_data_d = pix_data[23:16];
        byte_idx_d = BYTE_G;
        drv_en_d   = 1'b1;
        state_d    = ST_SEND;
        if (LAST_IDX != '0) begin
          pix_rd_d   = 1'b1;
          pix_addr_d = pix_addr_q + ADDR_W'(1);
        end
      end
      ST_SEND: begin
        if (drv_byte_done) begin
          if (byte_idx_q != BYTE_B) begin
            byte_idx_d = byte_idx_q + 2'd1;
            drv_data_d = pix_byte(cur_pix_q, byte_idx_d);
          end else if (pix_idx_q != LAST_IDX) begin
            cur_pix_d  = nxt_pix_q;
            drv_data_d = nxt_pix_q[23:16];
            byte_idx_d = BYTE_G;
            pix_idx_d  = pix_idx_q + ADDR_W'(1);
            // Keep the buffer one pixel ahead while any pixel remains unread.
            if (pix_idx_d != LAST_IDX) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = pix_addr_q + ADDR_W'(1);
            end
          end else begin
            drv_en_d = 1'b0;
            tmr_load = 1'b1;
            state_d  = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (tmr_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any byte progress in the same cycle.
    if (stop && (state_q == ST_FETCH || state_q == ST_LOAD || state_q == ST_SEND)) begin
      drv_en_d = 1'b0;
      pix_rd_d = 1'b0;
      tmr_load = 1'b1;
      state_d  = ST_LATCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pix_rd_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_idx_q  <= '0;
      byte_idx_q <= BYTE_G;
      cur_pix_q  <= '0;
      nxt_pix_q  <= '0;
      drv_en_q   <= 1'b0;
      drv_data_q <= '0;
      clkmax_q   <= '0;
      hi1_q      <= '0;
      hi0_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      pix_rd_q   <= pix_rd_d;
      rd_dly_q   <= rd_dly_d;
      pix_addr_q <= pix_addr_d;
      pix_idx_q  <= pix_idx_d;
      byte_idx_q <= byte_idx_d;
      cur_pix_q  <= cur_pix_d;
      nxt_pix_q  <= nxt_pix_d;
      drv_en_q   <= drv_en_d;
      drv_data_q <= drv_data_d;
      clkmax_q   <= clkmax_d;
      hi1_q      <= hi1_d;
      hi0_q      <= hi0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pix_rd     = pix_rd_q;
  assign pix_addr   = pix_addr_q;
  assign drv_en     = drv_en_q;
  assign drv_data   = drv_data_q;
  assign drv_clkmax = clkmax_q;
  assign drv_hi1    = hi1_q;
  assign drv_hi0    = hi0_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rgb_frame_ctrl.sv
// Randomized bench for rgb_frame_ctrl: a 3-LED and a 1-LED instance, pixel buffer and
// driver models, and an expected byte stream built directly from the pixel contents.
module tb_rgb_frame_ctrl;

  localparam int N0  = 3;
  localparam int LAT = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, byte_done = 1'b0;
  logic sel = 1'b0;
  logic [15:0] cfg_clkmax = '0, cfg_hi1 = '0, cfg_hi0 = '0;
  logic [23:0] pix_mem [16];

  logic        d0_pix_rd, d0_drv_en, d0_busy, d0_done;
  logic [3:0]  d0_pix_addr;
  logic [7:0]  d0_drv_data;
  logic [15:0] d0_clkmax, d0_hi1, d0_hi0;
  logic [23:0] d0_pix_data = '0;
  logic        d1_pix_rd, d1_drv_en, d1_busy, d1_done;
  logic [1:0]  d1_pix_addr;
  logic [7:0]  d1_drv_data;
  logic [15:0] d1_clkmax, d1_hi1, d1_hi0;
  logic [23:0] d1_pix_data = '0;

  always #5 clk = ~clk;

  rgb_frame_ctrl #(.NUM_LEDS(N0), .ADDR_W(4), .LATCH_CYCLES(LAT)) u_dut0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .stop(stop & ~sel),
    .cfg_clkmax(cfg_clkmax), .cfg_hi1(cfg_hi1), .cfg_hi0(cfg_hi0),
    .pix_rd(d0_pix_rd), .pix_addr(d0_pix_addr), .pix_data(d0_pix_data),
    .drv_en(d0_drv_en), .drv_data(d0_drv_data), .drv_clkmax(d0_clkmax),
    .drv_hi1(d0_hi1), .drv_hi0(d0_hi0), .drv_byte_done(byte_done & ~sel),
    .busy(d0_busy), .done(d0_done)
  );

  rgb_frame_ctrl #(.NUM_LEDS(1), .ADDR_W(2), .LATCH_CYCLES(LAT)) u_dut1 (
    .clk(clk), .reset(reset), .start(start & sel), .stop(stop & sel),
    .cfg_clkmax(cfg_clkmax), .cfg_hi1(cfg_hi1), .cfg_hi0(cfg_hi0),
    .pix_rd(d1_pix_rd), .pix_addr(d1_pix_addr), .pix_data(d1_pix_data),
    .drv_en(d1_drv_en), .drv_data(d1_drv_data), .drv_clkmax(d1_clkmax),
    .drv_hi1(d1_hi1), .drv_hi0(d1_hi0), .drv_byte_done(byte_done & sel),
    .busy(d1_busy), .done(d1_done)
  );

  // Synchronous pixel buffer: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    d0_pix_data <= d0_pix_rd ? pix_mem[d0_pix_addr] : 24'($urandom);
    d1_pix_data <= d1_pix_rd ? pix_mem[{2'b00, d1_pix_addr}] : 24'($urandom);
  end

  wire        m_pix_rd  = sel ? d1_pix_rd : d0_pix_rd;
  wire [7:0]  m_addr    = sel ? {6'd0, d1_pix_addr} : {4'd0, d0_pix_addr};
  wire        m_drv_en  = sel ? d1_drv_en : d0_drv_en;
  wire [7:0]  m_data    = sel ? d1_drv_data : d0_drv_data;
  wire [47:0] m_cfg     = sel ? {d1_clkmax, d1_hi1, d1_hi0} : {d0_clkmax, d0_hi1, d0_hi0};
  wire        m_busy    = sel ? d1_busy : d0_busy;
  wire        m_done    = sel ? d1_done : d0_done;

  int total = 0;
  int bad = 0;
  int rd_total = 0;
  int addr_bad = 0;
  int n_cur = N0;

  always @(negedge clk) begin
    if (m_pix_rd) begin
      rd_total++;
      if (int'(m_addr) > n_cur - 1) addr_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode 0: full frame; 1: stop after 'cut' bytes; 2: reset after 'cut' bytes.
  task automatic run_frame(input int mode, input int cut, input bit poke);
    int period, ph, bcnt, cyc, lat, low_cnt, cfg_bad, gap_bad, fall_cyc, stop_cyc, rd0;
    bit fell, got_done, pend, poked;
    logic [15:0] cm, h1, h0;
    logic [7:0] rx[$];
    logic [7:0] exp_b[$];
    n_cur = sel ? 1 : N0;
    period = $urandom_range(3, 30);
    cm = 16'($urandom); h1 = 16'($urandom); h0 = 16'($urandom);
    for (int p = 0; p < n_cur; p++)
      for (int b = 0; b < 3; b++) exp_b.push_back(8'(pix_mem[p] >> (16 - 8 * b)));
    if (mode != 0) while (exp_b.size() > cut) void'(exp_b.pop_back());

    @(negedge clk);
    rd0 = rd_total;
    cfg_clkmax = cm; cfg_hi1 = h1; cfg_hi0 = h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", m_busy, 1'b1);
    check("cfg_latched", m_cfg, {cm, h1, h0});
    cfg_clkmax = '0; cfg_hi1 = '0; cfg_hi0 = '0;
    lat = 1;
    while (!m_drv_en && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", lat, 3);

    ph = 0; bcnt = 0; cyc = 0; low_cnt = 0; cfg_bad = 0; gap_bad = 0;
    fall_cyc = -1; stop_cyc = -1; fell = 0; got_done = 0; pend = 0; poked = 0;
    while (!got_done && cyc < 9000) begin
      byte_done = 1'b0; stop = 1'b0; start = 1'b0;
      if (m_cfg != {cm, h1, h0}) cfg_bad++;
      if (m_done) begin
        got_done = 1;
        check("busy_at_done", m_busy, 1'b0);
        if (poke) start = 1'b1;
      end else begin
        if (!fell && !m_drv_en) begin fell = 1; fall_cyc = cyc; end
        if (fell) begin
          low_cnt++;
          if (m_drv_en || !m_busy) gap_bad++;
          if (poke && low_cnt == 100) start = 1'b1;
          if (poke && low_cnt == 200) stop = 1'b1;
        end
        if (pend) begin
          pend = 0;
          if (mode == 2) begin
            reset = 1'b1;
            @(negedge clk);
            check("rst_ctrl", {m_drv_en, m_pix_rd, m_busy, m_done}, 4'b0);
            check("rst_data", {m_data, m_addr, m_cfg}, 64'd0);
            reset = 1'b0;
            return;
          end
          stop = 1'b1; stop_cyc = cyc;
        end else if (!fell) begin
          if (poke && bcnt == 1 && !poked) begin start = 1'b1; poked = 1; end
          ph++;
          if (ph == period) begin
            ph = 0; byte_done = 1'b1; rx.push_back(m_data); bcnt++;
            if (mode != 0 && bcnt == cut) pend = 1;
          end
        end
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end

    check("done_seen", got_done, 1'b1);
    check("byte_count", rx.size(), exp_b.size());
    for (int i = 0; i < rx.size() && i < exp_b.size(); i++) check("byte", rx[i], exp_b[i]);
    check("latch_low_cycles", low_cnt, LAT);
    check("gap_en_busy", gap_bad, 0);
    check("cfg_hold", cfg_bad, 0);
    if (mode == 1) check("stop_to_low", fall_cyc - stop_cyc, 1);
    if (mode == 0) check("pix_rd_count", rd_total - rd0, n_cur);
    check("pix_addr_range", addr_bad, 0);
    @(negedge clk);
    start = 1'b0;
    check("done_single", m_done, 1'b0);
    repeat (6) @(negedge clk);
    check("idle_after", {m_busy, m_done, m_drv_en}, 3'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pix_mem[i] = 24'($urandom);
    repeat (3) @(negedge clk);
    check("rst0_ctrl", {d0_drv_en, d0_pix_rd, d0_busy, d0_done}, 4'b0);
    check("rst0_data", {d0_drv_data, d0_pix_addr, d0_clkmax, d0_hi1, d0_hi0}, 60'd0);
    check("rst1_ctrl", {d1_drv_en, d1_pix_rd, d1_busy, d1_done}, 4'b0);
    reset = 1'b0;

    // Idle corner cases: byte_done ignored, stop beats a simultaneous start.
    @(negedge clk); byte_done = 1'b1;
    @(negedge clk); byte_done = 1'b0; start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("idle_ignore", {d0_busy, d0_drv_en, d0_pix_rd, d0_drv_data}, 11'd0);

    sel = 1'b0;
    pix_mem[0] = 24'h112233; pix_mem[1] = 24'hAABBCC; pix_mem[2] = 24'($urandom);
    run_frame(0, 0, 1'b0);
    for (int i = 0; i < N0; i++) pix_mem[i] = 24'($urandom);
    run_frame(0, 0, 1'b1);
    run_frame(1, 2, 1'b0);
    for (int i = 0; i < N0; i++) pix_mem[i] = 24'($urandom);
    run_frame(1, $urandom_range(1, 3 * N0 - 1), 1'b1);
    run_frame(2, 4, 1'b0);
    for (int i = 0; i < N0; i++) pix_mem[i] = 24'($urandom);
    run_frame(0, 0, 1'b0);

    sel = 1'b1;
    pix_mem[0] = 24'h00FF80;
    run_frame(0, 0, 1'b0);
    pix_mem[0] = 24'($urandom);
    run_frame(0, 0, 1'b1);
    run_frame(1, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
